// File: rtl/rf_write_queue.sv
// rtl/rf_write_queue.sv - in-order register-file write queue with ALU/load producers and bypass lookup
// Optional high-water mark (HWM/HWM_CLR) built when RF_WRITE_QUEUE_WATERMARK_EN is defined.
module rf_write_queue #(
  parameter int addWidth  = 5,
  parameter int dataWidth = 32,
  parameter int DEPTH     = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       A_VLD,
  input  logic [addWidth-1:0]        A_ADDR,
  input  logic [dataWidth-1:0]       A_DATA,
  output logic                       A_RDY,
  input  logic                       M_VLD,
  input  logic [addWidth-1:0]        M_ADDR,
  input  logic [dataWidth-1:0]       M_DATA,
  output logic                       M_RDY,
  input  logic                       DRAIN,
  output logic                       WE3,
  output logic [addWidth-1:0]        A3,
  output logic [dataWidth-1:0]       WD3,
  input  logic [addWidth-1:0]        BYP_ADDR,
  output logic                       BYP_HIT,
  output logic [dataWidth-1:0]       BYP_DATA,
`ifdef RF_WRITE_QUEUE_WATERMARK_EN
  input  logic                       HWM_CLR,
  output logic [$clog2(DEPTH):0]     HWM,
`endif
  output logic [$clog2(DEPTH):0]     COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] C_FULL1 = CW'(DEPTH - 1);

  logic [addWidth-1:0]  r_addr [DEPTH];
  logic [dataWidth-1:0] r_data [DEPTH];
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_wr_ptr;
  logic [CW-1:0]        r_count;

  logic                 w_a_store;
  logic                 w_m_store;
  logic                 w_pop;
  logic [PW-1:0]        w_m_ptr;
  logic [CW-1:0]        w_count_next;

  // Readiness depends on registered occupancy only; M reserves a slot so both can land together.
  assign A_RDY = (r_count < C_FULL);
  assign M_RDY = (r_count < C_FULL1);

  // Address-0 writes complete the handshake but are never stored.
  assign w_a_store = A_VLD && A_RDY && (A_ADDR != '0);
  assign w_m_store = M_VLD && M_RDY && (M_ADDR != '0);
  assign w_m_ptr   = r_wr_ptr + PW'(w_a_store);

  assign w_pop = DRAIN && (r_count != '0);
  assign WE3   = w_pop;
  assign A3    = r_addr[r_rd_ptr];
  assign WD3   = r_data[r_rd_ptr];
  assign COUNT = r_count;

  assign w_count_next = r_count + CW'(w_a_store) + CW'(w_m_store) - CW'(w_pop);

  always_ff @(posedge CLK) begin
    if (w_a_store) begin
      r_addr[r_wr_ptr] <= A_ADDR;
      r_data[r_wr_ptr] <= A_DATA;
    end
    if (w_m_store) begin
      r_addr[w_m_ptr] <= M_ADDR;
      r_data[w_m_ptr] <= M_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_wr_ptr <= r_wr_ptr + PW'(w_a_store) + PW'(w_m_store);
      r_count  <= w_count_next;
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    BYP_HIT  = 1'b0;
    BYP_DATA = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (BYP_ADDR != '0) &&
          (r_addr[r_rd_ptr + PW'(i)] == BYP_ADDR)) begin
        BYP_HIT  = 1'b1;
        BYP_DATA = r_data[r_rd_ptr + PW'(i)];
      end
    end
  end

`ifdef RF_WRITE_QUEUE_WATERMARK_EN
  logic [CW-1:0] r_hwm;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hwm <= '0;
    end else if (HWM_CLR) begin
      r_hwm <= r_count;
    end else if (r_count > r_hwm) begin
      r_hwm <= r_count;
    end
  end

  assign HWM = r_hwm;
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
// tb/tb_rf_write_queue.sv - directed self-checking bench for rf_write_queue
module tb_rf_write_queue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        A_VLD;
  logic [4:0]  A_ADDR;
  logic [31:0] A_DATA;
  logic        A_RDY;
  logic        M_VLD;
  logic [4:0]  M_ADDR;
  logic [31:0] M_DATA;
  logic        M_RDY;
  logic        DRAIN;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [4:0]  BYP_ADDR;
  logic        BYP_HIT;
  logic [31:0] BYP_DATA;
  logic [2:0]  COUNT;
`ifdef RF_WRITE_QUEUE_WATERMARK_EN
  logic        HWM_CLR;
  logic [2:0]  HWM;
`endif

  int errors = 0;
  int checks = 0;

  rf_write_queue dut (
    .CLK(CLK), .RST(RST),
    .A_VLD(A_VLD), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_RDY(A_RDY),
    .M_VLD(M_VLD), .M_ADDR(M_ADDR), .M_DATA(M_DATA), .M_RDY(M_RDY),
    .DRAIN(DRAIN), .WE3(WE3), .A3(A3), .WD3(WD3),
    .BYP_ADDR(BYP_ADDR), .BYP_HIT(BYP_HIT), .BYP_DATA(BYP_DATA),
`ifdef RF_WRITE_QUEUE_WATERMARK_EN
    .HWM_CLR(HWM_CLR), .HWM(HWM),
`endif
    .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    A_VLD = 0; A_ADDR = 0; A_DATA = 0;
    M_VLD = 0; M_ADDR = 0; M_DATA = 0;
    DRAIN = 0; BYP_ADDR = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    tick();
    tick();
    RST = 0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (WE3 !== 1'b0 || COUNT !== 3'd0 || A_RDY !== 1'b1 || M_RDY !== 1'b1 || BYP_HIT !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: WE3=%b COUNT=%0d A_RDY=%b M_RDY=%b BYP_HIT=%b, want 0 0 1 1 0",
                 c, WE3, COUNT, A_RDY, M_RDY, BYP_HIT);
      end
      tick();
    end
  endtask

  task automatic test_single();
    A_VLD = 1; A_ADDR = 5; A_DATA = 32'hDEADBEEF; DRAIN = 1;
    checks++;
    if (A_RDY !== 1'b1 || WE3 !== 1'b0) begin
      errors++;
      $display("FAIL single_pre: A_RDY=%b WE3=%b, want 1 0", A_RDY, WE3);
    end
    tick();
    A_VLD = 0;
    checks++;
    if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hDEADBEEF || COUNT !== 3'd1) begin
      errors++;
      $display("FAIL single_write: WE3=%b A3=%0d WD3=%h COUNT=%0d, want 1 5 deadbeef 1", WE3, A3, WD3, COUNT);
    end
    tick();
    checks++;
    if (WE3 !== 1'b0 || COUNT !== 3'd0) begin
      errors++;
      $display("FAIL single_after: WE3=%b COUNT=%0d, want 0 0", WE3, COUNT);
    end
    DRAIN = 0;
  endtask

  task automatic test_dual_bypass();
    A_VLD = 1; A_ADDR = 3; A_DATA = 32'h11;
    M_VLD = 1; M_ADDR = 3; M_DATA = 32'h22;
    BYP_ADDR = 3;
    checks++;
    if (BYP_HIT !== 1'b0) begin
      errors++;
      $display("FAIL dual_incoming_not_searched: BYP_HIT=%b, want 0", BYP_HIT);
    end
    tick();
    A_VLD = 0; M_VLD = 0;
    checks++;
    if (COUNT !== 3'd2 || BYP_HIT !== 1'b1 || BYP_DATA !== 32'h22) begin
      errors++;
      $display("FAIL dual_bypass: COUNT=%0d HIT=%b DATA=%h, want 2 1 00000022", COUNT, BYP_HIT, BYP_DATA);
    end
    BYP_ADDR = 4;
    #1;
    checks++;
    if (BYP_HIT !== 1'b0 || BYP_DATA !== 32'h0) begin
      errors++;
      $display("FAIL dual_bypass_miss: HIT=%b DATA=%h, want 0 00000000", BYP_HIT, BYP_DATA);
    end
    DRAIN = 1;
    #1;
    checks++;
    if (WE3 !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'h11) begin
      errors++;
      $display("FAIL dual_first: WE3=%b A3=%0d WD3=%h, want 1 3 00000011", WE3, A3, WD3);
    end
    tick();
    checks++;
    if (WE3 !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'h22) begin
      errors++;
      $display("FAIL dual_second: WE3=%b A3=%0d WD3=%h, want 1 3 00000022", WE3, A3, WD3);
    end
    tick();
    checks++;
    if (WE3 !== 1'b0 || COUNT !== 3'd0) begin
      errors++;
      $display("FAIL dual_empty: WE3=%b COUNT=%0d, want 0 0", WE3, COUNT);
    end
    DRAIN = 0; BYP_ADDR = 0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      A_VLD = 1; A_ADDR = 5'(i + 1); A_DATA = 32'h100 + i;
      tick();
      if (i == 2) begin
        checks++;
        if (COUNT !== 3'd3 || M_RDY !== 1'b0 || A_RDY !== 1'b1) begin
          errors++;
          $display("FAIL full_at3: COUNT=%0d M_RDY=%b A_RDY=%b, want 3 0 1", COUNT, M_RDY, A_RDY);
        end
      end
    end
    checks++;
    if (COUNT !== 3'd4 || M_RDY !== 1'b0 || A_RDY !== 1'b0) begin
      errors++;
      $display("FAIL full_at4: COUNT=%0d M_RDY=%b A_RDY=%b, want 4 0 0", COUNT, M_RDY, A_RDY);
    end
    A_VLD = 1; A_ADDR = 9; A_DATA = 32'hBAD;
    tick();
    A_VLD = 0;
    BYP_ADDR = 9;
    #1;
    checks++;
    if (COUNT !== 3'd4 || BYP_HIT !== 1'b0) begin
      errors++;
      $display("FAIL full_reject: COUNT=%0d BYP_HIT=%b, want 4 0", COUNT, BYP_HIT);
    end
    BYP_ADDR = 2;
    #1;
    checks++;
    if (BYP_HIT !== 1'b1 || BYP_DATA !== 32'h101) begin
      errors++;
      $display("FAIL full_bypass: HIT=%b DATA=%h, want 1 00000101", BYP_HIT, BYP_DATA);
    end
    BYP_ADDR = 0;
    DRAIN = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (WE3 !== 1'b1 || A3 !== 5'(i + 1) || WD3 !== 32'h100 + i) begin
        errors++;
        $display("FAIL full_drain%0d: WE3=%b A3=%0d WD3=%h, want 1 %0d %h", i, WE3, A3, WD3, i + 1, 32'h100 + i);
      end
      tick();
    end
    checks++;
    if (WE3 !== 1'b0 || COUNT !== 3'd0) begin
      errors++;
      $display("FAIL full_empty: WE3=%b COUNT=%0d, want 0 0", WE3, COUNT);
    end
    DRAIN = 0;
  endtask

  task automatic test_addr_zero();
    A_VLD = 1; A_ADDR = 0; A_DATA = 32'h55;
    M_VLD = 1; M_ADDR = 0; M_DATA = 32'h56;
    DRAIN = 1;
    checks++;
    if (A_RDY !== 1'b1 || M_RDY !== 1'b1) begin
      errors++;
      $display("FAIL zero_handshake: A_RDY=%b M_RDY=%b, want 1 1", A_RDY, M_RDY);
    end
    tick();
    A_VLD = 0; M_VLD = 0;
    checks++;
    if (COUNT !== 3'd0 || WE3 !== 1'b0) begin
      errors++;
      $display("FAIL zero_not_stored: COUNT=%0d WE3=%b, want 0 0", COUNT, WE3);
    end
    DRAIN = 0;
    A_VLD = 1; A_ADDR = 1; A_DATA = 32'h0;
    tick();
    A_VLD = 0;
    BYP_ADDR = 0;
    #1;
    checks++;
    if (COUNT !== 3'd1 || BYP_HIT !== 1'b0 || BYP_DATA !== 32'h0) begin
      errors++;
      $display("FAIL zero_bypass: COUNT=%0d HIT=%b DATA=%h, want 1 0 00000000", COUNT, BYP_HIT, BYP_DATA);
    end
    DRAIN = 1;
    tick();
    DRAIN = 0;
  endtask

  task automatic test_back_to_back();
    DRAIN = 1;
    for (int i = 0; i < 3; i++) begin
      A_VLD = 1; A_ADDR = 5'(10 + i); A_DATA = 32'hA0 + i;
      tick();
      checks++;
      if (WE3 !== 1'b1 || A3 !== 5'(10 + i) || WD3 !== 32'hA0 + i || COUNT !== 3'd1) begin
        errors++;
        $display("FAIL b2b%0d: WE3=%b A3=%0d WD3=%h COUNT=%0d, want 1 %0d %h 1",
                 i, WE3, A3, WD3, COUNT, 10 + i, 32'hA0 + i);
      end
    end
    A_VLD = 0;
    tick();
    checks++;
    if (COUNT !== 3'd0 || WE3 !== 1'b1 - 1'b1) begin
      errors++;
      $display("FAIL b2b_empty: COUNT=%0d WE3=%b, want 0 0", COUNT, WE3);
    end
    DRAIN = 0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      A_VLD = 1; A_ADDR = 5'(7 + i); A_DATA = 32'hAAA0 + i;
      tick();
    end
    A_VLD = 0;
    checks++;
    if (COUNT !== 3'd3) begin
      errors++;
      $display("FAIL mid_fill: COUNT=%0d, want 3", COUNT);
    end
    RST = 1;
    tick();
    RST = 0;
    DRAIN = 1;
    BYP_ADDR = 7;
    #1;
    checks++;
    if (COUNT !== 3'd0 || WE3 !== 1'b0 || BYP_HIT !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: COUNT=%0d WE3=%b HIT=%b, want 0 0 0", COUNT, WE3, BYP_HIT);
    end
    A_VLD = 1; A_ADDR = 7; A_DATA = 32'h77;
    tick();
    A_VLD = 0;
    checks++;
    if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'h77) begin
      errors++;
      $display("FAIL mid_fresh: WE3=%b A3=%0d WD3=%h, want 1 7 00000077", WE3, A3, WD3);
    end
    tick();
    checks++;
    if (WE3 !== 1'b0 || COUNT !== 3'd0) begin
      errors++;
      $display("FAIL mid_done: WE3=%b COUNT=%0d, want 0 0", WE3, COUNT);
    end
    DRAIN = 0; BYP_ADDR = 0;
  endtask

`ifdef RF_WRITE_QUEUE_WATERMARK_EN
  task automatic test_watermark();
    HWM_CLR = 1;
    tick();
    HWM_CLR = 0;
    for (int i = 0; i < 2; i++) begin
      A_VLD = 1; A_ADDR = 5'(20 + i); A_DATA = 32'h1;
      tick();
    end
    A_VLD = 0;
    tick();
    checks++;
    if (HWM !== 3'd2) begin
      errors++;
      $display("FAIL hwm_peak: HWM=%0d, want 2", HWM);
    end
    DRAIN = 1;
    tick();
    tick();
    DRAIN = 0;
    HWM_CLR = 1;
    tick();
    HWM_CLR = 0;
    checks++;
    if (HWM !== 3'd0) begin
      errors++;
      $display("FAIL hwm_clear: HWM=%0d, want 0", HWM);
    end
  endtask
`endif

  initial begin
`ifdef RF_WRITE_QUEUE_WATERMARK_EN
    HWM_CLR = 0;
`endif
    test_reset();
    test_single();
    test_dual_bypass();
    test_full();
    test_addr_zero();
    test_back_to_back();
    test_reset_mid();
`ifdef RF_WRITE_QUEUE_WATERMARK_EN
    test_watermark();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
